// File: rtl/amp_frame_receiver.sv
// amp_frame_receiver
//
// Receive side of the UWB link, placed directly after the power-amplifier
// output. It gives an on-chip loopback point for checking the transmit chain.
// The serial stream idles low. Each bit is held for BIT_CYCLES clocks.
//
// Frame format, 11 slots, LSB first:
//   start(1), D0..D7, P (even parity), stop(0)
//
// The receiver looks for a rising edge of the synchronized line. It samples
// the centre of each slot, then reports the frame with a one-cycle strobe on
// exactly one of DATA_VALID, PARITY_ERR or FRAME_ERR.
//
// Ports
//   CLK          system clock, rising edge
//   RST          synchronous reset, active low
//   AMP_IN       serial amplifier stream, asynchronous to CLK
//   DATA         last good payload byte (holds between good frames)
//   DATA_VALID   one-cycle strobe, DATA updated this cycle
//   PARITY_ERR   one-cycle strobe, frame with bad parity
//   FRAME_ERR    one-cycle strobe, stop bit sampled high
//   BUSY         high whenever the receiver is not idle
//   FRAME_COUNT  count of good frames, wraps
module amp_frame_receiver #(
    parameter int BIT_CYCLES = 16,
    parameter int CNT_W      = 8
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             AMP_IN,
    output logic [7:0]       DATA,
    output logic             DATA_VALID,
    output logic             PARITY_ERR,
    output logic             FRAME_ERR,
    output logic             BUSY,
    output logic [CNT_W-1:0] FRAME_COUNT
);

    localparam int BC_W = (BIT_CYCLES > 2) ? $clog2(BIT_CYCLES) : 1;

    // The first sample lands half a bit after the edge. Every later sample
    // lands a full bit after the previous one.
    localparam logic [BC_W-1:0] HALF_RELOAD = BC_W'(BIT_CYCLES / 2 - 1);
    localparam logic [BC_W-1:0] FULL_RELOAD = BC_W'(BIT_CYCLES - 1);
    localparam logic [3:0]      LAST_DATA_SLOT = 4'd8;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_PARITY,
        ST_STOP,
        ST_WAIT_IDLE
    } state_t;

    state_t            state_q, state_d;
    logic              sync1_q, sync1_d;
    logic              sync2_q, sync2_d;
    logic              prev_q, prev_d;
    logic [BC_W-1:0]   bit_cnt_q, bit_cnt_d;
    logic [3:0]        slot_q, slot_d;
    logic [7:0]        shift_q, shift_d;
    logic              par_q, par_d;
    logic [7:0]        data_q, data_d;
    logic              data_valid_q, data_valid_d;
    logic              parity_err_q, parity_err_d;
    logic              frame_err_q, frame_err_d;
    logic [CNT_W-1:0]  frame_count_q, frame_count_d;

    logic s;
    logic rise;
    logic sample_pt;

    assign s         = sync2_q;
    assign rise      = sync2_q & ~prev_q;
    assign sample_pt = (bit_cnt_q == '0);

    always_comb begin
        state_d       = state_q;
        sync1_d       = AMP_IN;
        sync2_d       = sync1_q;
        prev_d        = sync2_q;
        bit_cnt_d     = bit_cnt_q;
        slot_d        = slot_q;
        shift_d       = shift_q;
        par_d         = par_q;
        data_d        = data_q;
        data_valid_d  = 1'b0;
        parity_err_d  = 1'b0;
        frame_err_d   = 1'b0;
        frame_count_d = frame_count_q;

        // One free-running bit timer serves every slot. It is reloaded at the
        // start edge and again at each sample point.
        if (state_q != ST_IDLE) begin
            bit_cnt_d = sample_pt ? FULL_RELOAD : bit_cnt_q - 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (rise) begin
                    state_d   = ST_START;
                    bit_cnt_d = HALF_RELOAD;
                end
            end
            ST_START: begin
                if (sample_pt) begin
                    // A start bit that has already dropped at mid-slot is a glitch.
                    if (!s) begin
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_DATA;
                        slot_d  = 4'd1;
                    end
                end
            end
            ST_DATA: begin
                if (sample_pt) begin
                    shift_d = {s, shift_q[7:1]};
                    slot_d  = slot_q + 4'd1;
                    if (slot_q == LAST_DATA_SLOT) begin
                        state_d = ST_PARITY;
                    end
                end
            end
            ST_PARITY: begin
                if (sample_pt) begin
                    par_d   = s;
                    state_d = ST_STOP;
                end
            end
            ST_STOP: begin
                if (sample_pt) begin
                    if (s) begin
                        // Framing failure takes priority; parity is not reported.
                        frame_err_d = 1'b1;
                        state_d     = ST_WAIT_IDLE;
                    end else if (^{shift_q, par_q}) begin
                        parity_err_d = 1'b1;
                        state_d      = ST_IDLE;
                    end else begin
                        data_d        = shift_q;
                        data_valid_d  = 1'b1;
                        frame_count_d = frame_count_q + 1'b1;
                        state_d       = ST_IDLE;
                    end
                end
            end
            ST_WAIT_IDLE: begin
                // Hold off until the line drops so a stuck-high line cannot re-arm.
                if (!s) begin
                    state_d = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge CLK) begin
        if (!RST) begin
            state_q       <= ST_IDLE;
            sync1_q       <= 1'b0;
            sync2_q       <= 1'b0;
            prev_q        <= 1'b0;
            data_q        <= 8'h00;
            data_valid_q  <= 1'b0;
            parity_err_q  <= 1'b0;
            frame_err_q   <= 1'b0;
            frame_count_q <= '0;
        end else begin
            state_q       <= state_d;
            sync1_q       <= sync1_d;
            sync2_q       <= sync2_d;
            prev_q        <= prev_d;
            data_q        <= data_d;
            data_valid_q  <= data_valid_d;
            parity_err_q  <= parity_err_d;
            frame_err_q   <= frame_err_d;
            frame_count_q <= frame_count_d;
        end
    end

    // These registers are always written before they are read within a frame.
    always_ff @(posedge CLK) begin
        bit_cnt_q <= bit_cnt_d;
        slot_q    <= slot_d;
        shift_q   <= shift_d;
        par_q     <= par_d;
    end

    assign DATA        = data_q;
    assign DATA_VALID  = data_valid_q;
    assign PARITY_ERR  = parity_err_q;
    assign FRAME_ERR   = frame_err_q;
    assign BUSY        = (state_q != ST_IDLE);
    assign FRAME_COUNT = frame_count_q;

endmodule

// File: tb/tb_amp_frame_receiver.sv
module tb_amp_frame_receiver;

    localparam int BC = 16;
    localparam int H  = BC / 2;

    logic CLK = 1'b0;
    logic RST = 1'b0;
    logic AMP_IN = 1'b0;

    logic [7:0] data_a, data_b;
    logic       dv_a, dv_b, pe_a, pe_b, fe_a, fe_b, busy_a, busy_b;
    logic [7:0] cnt_a;
    logic [1:0] cnt_b;

    always #5 CLK = ~CLK;

    amp_frame_receiver #(.BIT_CYCLES(BC), .CNT_W(8)) dut_a (
        .CLK(CLK), .RST(RST), .AMP_IN(AMP_IN),
        .DATA(data_a), .DATA_VALID(dv_a), .PARITY_ERR(pe_a),
        .FRAME_ERR(fe_a), .BUSY(busy_a), .FRAME_COUNT(cnt_a)
    );

    amp_frame_receiver #(.BIT_CYCLES(BC), .CNT_W(2)) dut_b (
        .CLK(CLK), .RST(RST), .AMP_IN(AMP_IN),
        .DATA(data_b), .DATA_VALID(dv_b), .PARITY_ERR(pe_b),
        .FRAME_ERR(fe_b), .BUSY(busy_b), .FRAME_COUNT(cnt_b)
    );

    int n_assert = 0;
    int n_fail   = 0;
    int cyc      = 0;

    // Reference model. It works on sample times computed from the edge cycle:
    // slot k is sampled at t0 + H + k*BC.
    typedef enum logic [1:0] {M_IDLE, M_FRAME, M_WAIT} mode_t;
    mode_t       mode    = M_IDLE;
    logic        m_s1    = 1'b0;
    logic        m_s     = 1'b0;
    logic        m_prev  = 1'b0;
    int          t0      = 0;
    logic [10:0] fbits   = '0;
    int          m_count = 0;
    logic [7:0]  e_data  = 8'h00;
    logic        e_dv    = 1'b0;
    logic        e_pe    = 1'b0;
    logic        e_fe    = 1'b0;
    logic        e_busy  = 1'b0;

    always @(posedge CLK) begin : model_p
        mode_t       md;
        logic [10:0] fb;
        logic [7:0]  ed;
        logic        edv, epe, efe;
        int          cnt, tz, j, k;
        md = mode; fb = fbits; ed = e_data; cnt = m_count; tz = t0;
        edv = 1'b0; epe = 1'b0; efe = 1'b0;
        if (!RST) begin
            md  = M_IDLE;
            ed  = 8'h00;
            cnt = 0;
            m_s1   <= 1'b0;
            m_s    <= 1'b0;
            m_prev <= 1'b0;
        end else begin
            case (md)
                M_IDLE: begin
                    if (m_s && !m_prev) begin
                        md = M_FRAME;
                        tz = cyc;
                    end
                end
                M_FRAME: begin
                    j = cyc - tz;
                    if (j >= H && ((j - H) % BC) == 0) begin
                        k = (j - H) / BC;
                        fb[k] = m_s;
                        if (k == 0 && !m_s) begin
                            md = M_IDLE;
                        end else if (k == 10) begin
                            if (fb[10]) begin
                                efe = 1'b1;
                                md  = M_WAIT;
                            end else if (^fb[9:1]) begin
                                epe = 1'b1;
                                md  = M_IDLE;
                            end else begin
                                ed  = fb[8:1];
                                edv = 1'b1;
                                cnt = cnt + 1;
                                md  = M_IDLE;
                            end
                        end
                    end
                end
                default: begin
                    if (!m_s) md = M_IDLE;
                end
            endcase
            m_prev <= m_s;
            m_s    <= m_s1;
            m_s1   <= AMP_IN;
        end
        mode    <= md;
        fbits   <= fb;
        e_data  <= ed;
        m_count <= cnt;
        t0      <= tz;
        e_dv    <= edv;
        e_pe    <= epe;
        e_fe    <= efe;
        e_busy  <= (md != M_IDLE);
        cyc     <= cyc + 1;
    end

    int         dv_total = 0, pe_total = 0, fe_total = 0, busy_total = 0;
    int         last_dv_cyc = 0;
    logic [7:0] dv_log[$];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_assert++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h (cycle %0d)", nm, act, exp, cyc);
        end
    endtask

    // Advance one cycle and compare both instances against the model.
    task automatic tick();
        @(negedge CLK);
        check("data_a", 32'(data_a), 32'(e_data));
        check("dv_a", 32'(dv_a), 32'(e_dv));
        check("pe_a", 32'(pe_a), 32'(e_pe));
        check("fe_a", 32'(fe_a), 32'(e_fe));
        check("busy_a", 32'(busy_a), 32'(e_busy));
        check("cnt_a", 32'(cnt_a), 32'(m_count & 255));
        check("data_b", 32'(data_b), 32'(e_data));
        check("dv_b", 32'(dv_b), 32'(e_dv));
        check("pe_b", 32'(pe_b), 32'(e_pe));
        check("fe_b", 32'(fe_b), 32'(e_fe));
        check("busy_b", 32'(busy_b), 32'(e_busy));
        check("cnt_b", 32'(cnt_b), 32'(m_count & 3));
        if (dv_a) begin
            dv_total++;
            last_dv_cyc = cyc;
            dv_log.push_back(data_a);
        end
        if (pe_a) pe_total++;
        if (fe_a) fe_total++;
        if (busy_a) busy_total++;
    endtask

    task automatic idle(input int n);
        AMP_IN = 1'b0;
        repeat (n) tick();
    endtask

    task automatic send_bit(input logic b);
        AMP_IN = b;
        repeat (BC) tick();
    endtask

    task automatic send_frame(input logic [7:0] b, input logic pflip, input logic stop);
        send_bit(1'b1);
        for (int i = 0; i < 8; i++) send_bit(b[i]);
        send_bit((^b) ^ pflip);
        send_bit(stop);
    endtask

    task automatic do_reset();
        AMP_IN = 1'b0;
        RST = 1'b0;
        repeat (3) tick();
        RST = 1'b1;
        tick();
    endtask

    initial begin : stim
        int c, d0, p0, f0, b0, base;
        do_reset();
        check("rst_data", 32'(data_a), 32'h0);
        check("rst_busy", 32'(busy_a), 32'h0);
        check("rst_cnt", 32'(cnt_a), 32'h0);
        idle(5);

        // Good frame 0x5A: strobe 2 sync cycles + 8 + 160 + 1 after the line rises
        c = cyc; d0 = dv_total; p0 = pe_total; f0 = fe_total;
        send_frame(8'h5A, 1'b0, 1'b0);
        idle(10);
        check("t1_dv_count", 32'(dv_total - d0), 32'd1);
        check("t1_dv_latency", 32'(last_dv_cyc - c), 32'd171);
        check("t1_data", 32'(data_a), 32'h5A);
        check("t1_cnt", 32'(cnt_a), 32'd1);
        check("t1_errs", 32'((pe_total - p0) + (fe_total - f0)), 32'd0);

        // Bad parity
        do_reset();
        d0 = dv_total; p0 = pe_total;
        send_frame(8'h5A, 1'b1, 1'b0);
        idle(10);
        check("t2_pe_count", 32'(pe_total - p0), 32'd1);
        check("t2_dv_count", 32'(dv_total - d0), 32'd0);
        check("t2_data", 32'(data_a), 32'h00);
        check("t2_cnt", 32'(cnt_a), 32'd0);

        // Stop bit high, line stuck high for 40 more cycles
        d0 = dv_total; p0 = pe_total; f0 = fe_total;
        send_frame(8'h3C, 1'b0, 1'b1);
        b0 = busy_total;
        AMP_IN = 1'b1;
        repeat (40) tick();
        check("t3_busy_held", 32'(busy_total - b0), 32'd40);
        check("t3_busy_before_drop", 32'(busy_a), 32'd1);
        idle(5);
        check("t3_busy_after_drop", 32'(busy_a), 32'd0);
        b0 = busy_total;
        idle(30);
        check("t3_no_retrigger", 32'(busy_total - b0), 32'd0);
        check("t3_fe_count", 32'(fe_total - f0), 32'd1);
        check("t3_other", 32'((dv_total - d0) + (pe_total - p0)), 32'd0);

        // 4-cycle glitch
        d0 = dv_total; p0 = pe_total; f0 = fe_total; b0 = busy_total;
        AMP_IN = 1'b1;
        repeat (4) tick();
        idle(30);
        check("t4_busy_cycles", 32'(busy_total - b0), 32'd8);
        check("t4_strobes", 32'((dv_total - d0) + (pe_total - p0) + (fe_total - f0)), 32'd0);

        // Back-to-back frames
        do_reset();
        d0 = dv_total; base = dv_log.size();
        send_frame(8'h01, 1'b0, 1'b0);
        send_frame(8'hFF, 1'b0, 1'b0);
        send_frame(8'h80, 1'b0, 1'b0);
        idle(10);
        check("t5_dv_count", 32'(dv_total - d0), 32'd3);
        if (dv_log.size() >= base + 3) begin
            check("t5_byte0", 32'(dv_log[base]), 32'h01);
            check("t5_byte1", 32'(dv_log[base+1]), 32'hFF);
            check("t5_byte2", 32'(dv_log[base+2]), 32'h80);
        end
        check("t5_cnt", 32'(cnt_a), 32'd3);

        // Reset mid-DATA, then clean frames; narrow counter wraps
        do_reset();
        send_bit(1'b1);
        send_bit(1'b1);
        send_bit(1'b1);
        d0 = dv_total; p0 = pe_total; f0 = fe_total;
        do_reset();
        idle(10);
        check("t6_aborted", 32'((dv_total - d0) + (pe_total - p0) + (fe_total - f0)), 32'd0);
        send_frame(8'hC3, 1'b0, 1'b0);
        idle(5);
        check("t6_data", 32'(data_a), 32'hC3);
        check("t6_cnt", 32'(cnt_a), 32'd1);
        send_frame(8'h11, 1'b0, 1'b0);
        send_frame(8'h22, 1'b0, 1'b0);
        send_frame(8'h33, 1'b0, 1'b0);
        send_frame(8'h44, 1'b0, 1'b0);
        idle(10);
        check("t6_cnt5", 32'(cnt_a), 32'd5);
        check("t6_wrap_cnt", 32'(cnt_b), 32'd1);
        check("t6_data_hold", 32'(data_a), 32'h44);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/amp_frame_receiver.md
Name: amp_frame_receiver

Overview:
- Receive side of the UWB link; sits directly downstream of the power-amplifier output.
- Samples the serial amplified stream (idle low) on AMP_IN, where each bit is held for BIT_CYCLES clocks.
- Detects a start bit, recovers an 8-bit payload with even parity and a stop bit, and presents bytes with a one-cycle valid strobe plus error flags and a frame counter.
- Gives the team an on-chip loopback point for checking the transmit chain end to end.

Parameters:
- BIT_CYCLES, 16: clocks per transmitted bit; even, ≥4.
- CNT_W, 8: width of FRAME_COUNT.

Ports:
- CLK  input  1  system clock; all logic on rising edge.
- RST  input  1  synchronous, active-low reset.
- AMP_IN  input  1  serial stream from the amplifier; asynchronous to CLK.
- DATA  output  8  last good payload byte.
- DATA_VALID  output  1  one-cycle strobe when DATA is updated.
- PARITY_ERR  output  1  one-cycle strobe: frame received with bad parity.
- FRAME_ERR  output  1  one-cycle strobe: stop bit sampled high.
- BUSY  output  1  high whenever state ≠ IDLE.
- FRAME_COUNT  output  CNT_W  count of good frames; wraps.

Behaviour:
- Reset (RST=0 at a rising edge):
  - State goes to IDLE.
  - DATA=0, DATA_VALID=0, PARITY_ERR=0, FRAME_ERR=0, BUSY=0, FRAME_COUNT=0.
  - Both synchronizer flops and the edge register are cleared to 0.
  - Reset mid-frame abandons the frame; no strobes are produced.
- Input path:
  - AMP_IN passes through a 2-flop synchronizer to give s.
  - Rising edge = s==1 while previous s==0. The cycle in which the edge is seen is t0.
- Frame format: start(1), D0..D7 (LSB first), parity P, stop(0). That is 11 bit slots, k=0..10.
- Sample point for slot k: t0 + BIT_CYCLES/2 + k*BIT_CYCLES. A single bit-cycle counter is reloaded at t0.
- State machine:
  - IDLE: on rising edge → START.
  - START: at the slot-0 sample, if s==0 (glitch) → IDLE with no strobe; otherwise → DATA.
  - DATA: shift s in at each sample point for slots 1..8; after slot 8 → PARITY.
  - PARITY: capture P at slot 9 → STOP.
  - STOP: at slot 10, evaluate the frame:
    - Stop bit s==1: FRAME_ERR pulses the next cycle, DATA is unchanged → WAIT_IDLE. Parity is not reported.
    - Stop OK, parity odd (XOR of D0..D7,P == 1): PARITY_ERR pulses the next cycle, DATA is unchanged → IDLE.
    - Stop OK, parity good: DATA loads the byte and DATA_VALID pulses the next cycle, both in the same cycle. FRAME_COUNT increments in that same cycle, wrapping 2^CNT_W-1 → 0. → IDLE.
  - WAIT_IDLE: remain until s==0 → IDLE. This prevents a stuck-high line from re-triggering.
- Strobes are exactly one cycle wide. At most one of DATA_VALID, PARITY_ERR, FRAME_ERR is asserted per frame.
- Edges of s during START, DATA, PARITY or STOP are ignored; only the sample points matter.
- A new start edge is accepted from the first IDLE cycle after the strobe cycle. Back-to-back frames with a single idle-low stop slot must be received without loss.
- DATA holds its value between good frames.

Test Plan (BIT_CYCLES=16):
- Single frame 0x5A, parity 0, stop 0 → DATA_VALID one cycle at t0+8+160+1; DATA=0x5A; FRAME_COUNT=1; no error strobes.
- Frame 0x5A sent with parity bit 1 → PARITY_ERR one cycle; DATA unchanged (0); FRAME_COUNT=0.
- Frame 0x3C with stop bit 1, line then held high for 40 cycles before dropping → FRAME_ERR once; BUSY stays high until s falls; no re-trigger while the line is held high.
- 4-cycle high glitch on an idle line → returns to IDLE after the slot-0 sample; no strobes; BUSY high for 8 cycles only.
- Frames 0x01, 0xFF, 0x80 back to back → three DATA_VALID pulses with those values in order; FRAME_COUNT=3.
- Reset asserted mid-DATA, then a clean 0xC3 frame → no strobe from the aborted frame; 0xC3 received; FRAME_COUNT=1. With CNT_W=2, five good frames → FRAME_COUNT=1 (wrap).
